// File: rtl/multi_chan_fifo_if.sv
// Handshake bundle for multi_chan_fifo: push side (chan/data/valid/ready)
// and pop side (chan/data/valid/ready); slave = FIFO, master = client.
interface multi_chan_fifo_if #(
  parameter type T     = logic [7:0],
  parameter int  ChanW = 2
);
  logic [ChanW-1:0] in_chan_i;
  T                 in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  T                 out_data_o;
  logic [ChanW-1:0] out_chan_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    output in_chan_i, in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_chan_o, out_valid_o
  );

  modport slave (
    input  in_chan_i, in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_chan_o, out_valid_o
  );
endinterface

// File: rtl/multi_chan_fifo.sv
// NUM_CHAN independent FIFOs behind one push and one round-robin pop port.
// Ports: clk_i, rst_ni, clr_i, bus (slave handshake), fill_o, almost_full_o.
module multi_chan_fifo #(
  parameter int  WIDTH     = 8,
  parameter type T         = logic [WIDTH-1:0],
  parameter int  NUM_CHAN  = 4,
  parameter int  LOG_DEPTH = 2,
  parameter int  AF_THRESH = 2**LOG_DEPTH-1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_i,
  multi_chan_fifo_if.slave                  bus,
  output logic [NUM_CHAN-1:0][LOG_DEPTH:0]  fill_o,
  output logic [NUM_CHAN-1:0]               almost_full_o
);
  localparam int ChanW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int PtrW  = LOG_DEPTH + 1;
  localparam int Depth = 2**LOG_DEPTH;

  T mem [NUM_CHAN][Depth];

  logic [NUM_CHAN-1:0][PtrW-1:0] wptr_q;
  logic [NUM_CHAN-1:0][PtrW-1:0] rptr_q;
  logic [ChanW-1:0]              rr_q;
  logic [ChanW-1:0]              grant_q;
  logic                          lock_q;

  logic [NUM_CHAN-1:0] empty;
  logic [NUM_CHAN-1:0] full;
  logic                chan_ok;
  logic [ChanW-1:0]    arb_grant;
  logic [ChanW-1:0]    grant;
  logic                push;
  logic                pop;

  always_comb begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      empty[c] = wptr_q[c] == rptr_q[c];
      full[c]  = (wptr_q[c] ^ rptr_q[c])
                 == {1'b1, {LOG_DEPTH{1'b0}}};
      fill_o[c] = wptr_q[c] - rptr_q[c];
      almost_full_o[c] = fill_o[c] >= PtrW'(AF_THRESH);
    end
  end

  assign chan_ok = 32'(bus.in_chan_i) < NUM_CHAN;
  assign bus.in_ready_o = !clr_i && chan_ok
                          && !full[bus.in_chan_i];
  assign push = bus.in_valid_i && bus.in_ready_o;

  // First non-empty channel at or after rr_q, cyclically.
  always_comb begin
    int  idx;
    logic found;
    idx = 0;
    found = 1'b0;
    arb_grant = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      idx = (int'(rr_q) + i) % NUM_CHAN;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        arb_grant = ChanW'(idx);
      end
    end
  end

  // A presented but unaccepted word keeps its grant.
  assign grant = lock_q ? grant_q : arb_grant;

  assign bus.out_valid_o = !clr_i && !(&empty);
  assign bus.out_chan_o  = grant;
  assign bus.out_data_o  =
    mem[grant][rptr_q[grant][LOG_DEPTH-1:0]];
  assign pop = bus.out_valid_o && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[bus.in_chan_i][wptr_q[bus.in_chan_i][LOG_DEPTH-1:0]]
        <= bus.in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      if (push) begin
        wptr_q[bus.in_chan_i] <= wptr_q[bus.in_chan_i] + 1'b1;
      end
      if (pop) begin
        rptr_q[grant] <= rptr_q[grant] + 1'b1;
        lock_q <= 1'b0;
        rr_q <= (grant == ChanW'(NUM_CHAN - 1))
                ? '0 : grant + 1'b1;
      end else if (bus.out_valid_o) begin
        lock_q  <= 1'b1;
        grant_q <= grant;
      end
    end
  end

  a_chan_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.in_valid_i |-> chan_ok
  );
endmodule

// File: tb/tb_multi_chan_fifo.sv
// Scoreboard bench for multi_chan_fifo (4 chan, depth 4, AF_THRESH 3).
// Stimulus pushes expectations into queues; a monitor pops on handshakes.
module tb_multi_chan_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  multi_chan_fifo_if #(.T(logic [7:0]), .ChanW(2)) bus();
  logic [3:0][2:0] fill;
  logic [3:0]      af;

  multi_chan_fifo #(
    .WIDTH(8), .NUM_CHAN(4), .LOG_DEPTH(2), .AF_THRESH(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .bus(bus), .fill_o(fill), .almost_full_o(af)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q [4][$];
  logic [9:0] ord_q [$];
  logic acc;

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int ch;
    logic [9:0] o;
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      ch = int'(bus.out_chan_o);
      if (exp_q[ch].size() == 0)
        check("pop_unexpected_chan", ch, -1);
      else
        check("pop_data", int'(bus.out_data_o),
              int'(exp_q[ch].pop_front()));
      if (ord_q.size() > 0) begin
        o = ord_q.pop_front();
        check("pop_order",
              int'({bus.out_chan_o, bus.out_data_o}), int'(o));
      end
    end
  end

  task automatic cyc(input bit v, input int ch, input int d,
                     input bit r);
    bus.in_valid_i  = v;
    bus.in_chan_i   = 2'(ch);
    bus.in_data_i   = 8'(d);
    bus.out_ready_i = r;
    @(negedge clk);
    acc = v && bus.in_ready_o;
    if (acc) exp_q[ch].push_back(8'(d));
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    bus.out_ready_i = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      if (!bus.out_valid_o) break;
      k++;
    end
    check({name, "_drain_valid"}, int'(bus.out_valid_o), 0);
    check({name, "_model_left"},
          exp_q[0].size() + exp_q[1].size()
          + exp_q[2].size() + exp_q[3].size() + ord_q.size(), 0);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    int guard;
    bus.in_valid_i  = 1'b0;
    bus.in_chan_i   = '0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid_o), 0);
    check("rst_out_chan", int'(bus.out_chan_o), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_af", int'(af), 0);
    for (int c = 0; c < 4; c++) begin
      bus.in_chan_i = 2'(c);
      #1 check("rst_in_ready", int'(bus.in_ready_o), 1);
    end
    @(posedge clk);
    #1;

    for (int k = 0; k < 4; k++) begin
      cyc(1, 2, 8'hA0 + k, 0);
      check("full_push_acc", int'(acc), 1);
      if (k == 1) check("af_after2", int'(af[2]), 0);
      if (k == 2) check("af_after3", int'(af[2]), 1);
    end
    check("full_fill", int'(fill[2]), 4);
    cyc(1, 2, 8'hA4, 0);
    check("full_refused", int'(acc), 0);
    cyc(1, 0, 8'h55, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      check("lock_valid", int'(bus.out_valid_o), 1);
      check("lock_chan", int'(bus.out_chan_o), 2);
      check("lock_data", int'(bus.out_data_o), 8'hA0);
    end
    check("lock_fill2", int'(fill[2]), 4);
    ord_q.push_back({2'd2, 8'hA0});
    ord_q.push_back({2'd0, 8'h55});
    ord_q.push_back({2'd2, 8'hA1});
    ord_q.push_back({2'd2, 8'hA2});
    ord_q.push_back({2'd2, 8'hA3});
    drain("full");
    check("full_fill_after", int'(fill[2]), 0);

    cyc(1, 0, 8'h10, 0);
    cyc(1, 0, 8'h11, 0);
    cyc(1, 3, 8'h30, 0);
    cyc(1, 3, 8'h31, 0);
    ord_q.push_back({2'd0, 8'h10});
    ord_q.push_back({2'd3, 8'h30});
    ord_q.push_back({2'd0, 8'h11});
    ord_q.push_back({2'd3, 8'h31});
    drain("rr");

    cyc(1, 1, 8'h20, 0);
    cyc(1, 1, 8'h21, 0);
    check("sim_fill2", int'(fill[1]), 2);
    cyc(1, 1, 8'h22, 1);
    check("sim_push_acc", int'(acc), 1);
    check("sim_fill_same", int'(fill[1]), 2);
    cyc(1, 1, 8'h23, 0);
    cyc(1, 1, 8'h24, 0);
    check("sim_fill4", int'(fill[1]), 4);
    cyc(1, 1, 8'h25, 1);
    check("sim_full_refused", int'(acc), 0);
    check("sim_fill3", int'(fill[1]), 3);
    drain("sim");

    i = 0;
    guard = 0;
    while (i < 10 && guard < 300) begin
      cyc(1'($urandom_range(0, 1)), 1, i,
          1'($urandom_range(0, 1)));
      if (acc) i++;
      guard++;
    end
    check("wrap_pushed", i, 10);
    drain("wrap");
    check("wrap_fill", int'(fill[1]), 0);

    cyc(1, 0, 8'h01, 0);
    cyc(1, 2, 8'h02, 0);
    check("pre_clr_valid", int'(bus.out_valid_o), 1);
    bus.in_valid_i  = 1'b1;
    bus.in_chan_i   = 2'd1;
    bus.in_data_i   = 8'h77;
    bus.out_ready_i = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", int'(bus.in_ready_o), 0);
    check("clr_out_valid", int'(bus.out_valid_o), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    check("post_clr_fill", int'(fill), 0);
    check("post_clr_af", int'(af), 0);
    check("post_clr_valid", int'(bus.out_valid_o), 0);
    cyc(1, 3, 8'h33, 0);
    check("clr_grant_valid", int'(bus.out_valid_o), 1);
    check("clr_grant_chan", int'(bus.out_chan_o), 3);
    check("clr_grant_data", int'(bus.out_data_o), 8'h33);
    ord_q.push_back({2'd3, 8'h33});
    drain("clr");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_chan_fifo.md
# multi_chan_fifo

Single-clock, multi-channel FIFO. It holds `NUM_CHAN` independent queues of `2**LOG_DEPTH` entries each, behind one shared push port and one shared pop port. The pop port is round-robin arbitrated across non-empty channels. It sits in front of per-destination stream consumers, for example the source side of a CDC FIFO bank or a DMA channel mux. Per-channel fill level and almost-full flags are provided for upstream flow control.

## Interface
- `WIDTH`, default 8: payload width in bits.
- `T`, default `logic [WIDTH-1:0]`: payload type.
- `NUM_CHAN`, default 4: number of channels, ≥1.
- `LOG_DEPTH`, default 2: per-channel depth is `2**LOG_DEPTH`, ≥1.
- `AF_THRESH`, default `2**LOG_DEPTH-1`: almost-full asserts when fill ≥ `AF_THRESH`, range 1..`2**LOG_DEPTH`.
- `ChanW` (localparam): `max(1, $clog2(NUM_CHAN))`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clr_i`  in  1  synchronous clear of all channels.
- `in_chan_i`  in  ChanW  target channel of push.
- `in_data_i`  in  T  push payload.
- `in_valid_i`  in  1  push request.
- `in_ready_o`  out  1  selected channel can accept.
- `out_data_o`  out  T  head word of granted channel.
- `out_chan_o`  out  ChanW  granted channel index.
- `out_valid_o`  out  1  a granted word is presented.
- `out_ready_i`  in  1  consumer accepts.
- `fill_o`  out  NUM_CHAN×(LOG_DEPTH+1)  per-channel occupancy, 0..`2**LOG_DEPTH`.
- `almost_full_o`  out  NUM_CHAN  per-channel fill ≥ `AF_THRESH`.

## Operation
- **Pointers.** Each channel has binary `wptr` and `rptr` of width `LOG_DEPTH+1`, wrapping modulo `2**(LOG_DEPTH+1)`.
  - Empty: `wptr == rptr`.
  - Full: pointers differ only in the MSB.
  - `fill = wptr - rptr` (modular, LOG_DEPTH+1 bits).
  - Storage is addressed by the low `LOG_DEPTH` bits.
- **Push.**
  - `in_ready_o = !clr_i && in_chan_i < NUM_CHAN && !full[in_chan_i]`.
  - On `in_valid_i && in_ready_o`: write the word to `mem[in_chan_i][wptr]`, then increment `wptr`.
  - An out-of-range `in_chan_i` is never accepted; a simulation assertion fires if `in_valid_i` is high with an out-of-range channel.
- **Arbitration.**
  - Round-robin priority pointer `rr_q`.
  - The grant is the first non-empty channel at or after `rr_q`, cyclically.
  - `out_valid_o = !clr_i && any non-empty`.
  - `out_data_o = mem[grant][rptr[grant]]`.
- **Lock.** While `out_valid_o && !out_ready_i`, the grant register holds. `out_chan_o` and `out_data_o` stay stable even if other channels become non-empty.
- **Pop.** On `out_valid_o && out_ready_i`: increment `rptr[grant]`, release the lock, and set `rr_q <= grant+1` (mod `NUM_CHAN`).
- **Simultaneous push and pop, same channel.** Both occur; fill is unchanged.
- **Push to a full channel.** Refused even if that channel pops in the same cycle (no bypass); `in_ready_o` is computed from the registered state only.
- **Push to an empty channel.** The word is not visible on the pop port until the next cycle (no fall-through).
- **Clear.** When `clr_i` is high:
  - all pointers go to 0, `rr_q` goes to 0, and the lock is released on the next edge;
  - any push or pop in that cycle is ignored;
  - `in_ready_o` and `out_valid_o` are forced low in that cycle. This is the only permitted withdrawal of `out_valid_o` before a handshake.
- **Reset.** Same effect as clear. Storage is not reset.

## Timing
- **Reset values:**
  - `in_ready_o = 1` (for an in-range `in_chan_i`);
  - `out_valid_o = 0`, `out_chan_o = 0`, `fill_o = 0`, `almost_full_o = 0`;
  - `out_data_o` undefined.
- **Latency.** Push accepted at edge t → word can handshake on the pop port at earliest edge t+1.
- **Throughput.** One push and one pop per cycle.
- **Flag updates.** `fill_o` and `almost_full_o` are registered-pointer derived and update the cycle after a handshake.
- **Combinational paths:**
  - `in_chan_i` → `in_ready_o` (combinational);
  - `out_ready_i` → no output in the same cycle.

## Test plan
Configuration for all scenarios: NUM_CHAN=4, LOG_DEPTH=2, WIDTH=8, AF_THRESH=3.
- **Reset.** Release `rst_ni` with `in_valid_i=0` → `out_valid_o=0`, all `fill_o=0`, `almost_full_o=0000`, `in_ready_o=1` for chan 0..3 and 0 for an out-of-range chan (if `ChanW` allows one).
- **Full channel.** Push 0xA0..0xA3 to ch2 with `out_ready_i=0` → `almost_full_o[2]=1` after the 3rd push, `fill_o[2]=4`, `in_ready_o=0` for ch2 on the 5th attempt. `out_chan_o=2` and `out_data_o=0xA0` are held stable for 10 stalled cycles.
- **Round robin.** ch0 holds 0x10,0x11 and ch3 holds 0x30,0x31; set `out_ready_i=1` → pop order (0,0x10),(3,0x30),(0,0x11),(3,0x31), then `out_valid_o=0`.
- **Simultaneous events.**
  - ch1 at fill 2, push and pop in the same cycle → `fill_o[1]` stays 2.
  - ch1 at fill 4, push and pop in the same cycle → push refused, fill becomes 3.
- **Wrap-around.** Stream 0x00..0x09 through ch1 with random valid/ready → output order is exact and pointers wrap twice.
- **Clear mid-operation.** Assert `clr_i` for one cycle during an active stalled pop with ch0 and ch2 non-empty → next cycle all `fill_o=0` and `out_valid_o=0`. A subsequent push to ch3 is granted first (rr reset).
